// File: rtl/pio_mux_ctrl.sv
// Pin-mux and GPIO controller for one FPGA pin bank: Avalon-MM register file,
// hi-Z guard on selector changes, input synchronisers and sticky edge interrupts.
module pio_mux_ctrl #(
    parameter int PINS        = 32,
    parameter int FUNCS       = 4,
    parameter int GUARD       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         iCLK,
    input  logic                         iRESET,
    input  logic [5:0]                   iADDRESS,
    input  logic                         iREAD,
    input  logic                         iWRITE,
    input  logic [31:0]                  iWRITE_DATA,
    output logic [31:0]                  oREAD_DATA,
    input  logic [PINS-1:0]              iPIN_IN,
    input  logic [PINS*(FUNCS-1)-1:0]    iALT_OUT,
    input  logic [PINS*(FUNCS-1)-1:0]    iALT_OE,
    output logic [PINS-1:0]              oPIN_OUT,
    output logic [PINS-1:0]              oPIN_OE,
    output logic [PINS-1:0]              oSYNC_IN,
    output logic                         oIRQ
);
    localparam int SELW = $clog2(FUNCS);
    // One spare selector bit so out-of-range codes stay distinguishable and read back.
    localparam int MSW  = SELW + 1;

    logic [PINS-1:0] out_q, out_d, dir_q, dir_d;
    logic [PINS-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [PINS-1:0] status_q, status_d, prev_q, prev_d;
    logic [SYNC_STAGES-1:0][PINS-1:0] sync_q, sync_d;
    logic [PINS-1:0][MSW-1:0] msel_q, msel_d;
    logic [PINS-1:0][3:0]     guard_q, guard_d;
    logic [PINS-1:0] pin_out_q, pin_out_d, pin_oe_q, pin_oe_d;
    logic            irq_q, irq_d;
    logic [31:0]     rdata_q, rdata_d, rd_word;

    logic [PINS-1:0] wdata, clr, sync_out, rise, fall;

    assign wdata    = iWRITE_DATA[PINS-1:0];
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~prev_q;
    assign fall     = ~sync_out & prev_q;
    assign prev_d   = sync_out;

    if (SYNC_STAGES > 1) begin : g_sync_chain
        assign sync_d = {sync_q[SYNC_STAGES-2:0], iPIN_IN};
    end else begin : g_sync_single
        assign sync_d = iPIN_IN;
    end

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;
        if (iWRITE) begin
            case (iADDRESS)
                6'd1:    out_d     = wdata;
                6'd2:    dir_d     = wdata;
                6'd3:    rise_en_d = wdata;
                6'd4:    fall_en_d = wdata;
                6'd5:    clr       = wdata;
                6'd6:    out_d     = out_q | wdata;
                6'd7:    out_d     = out_q & ~wdata;
                default: ;
            endcase
        end
        // A fresh edge outranks a same-cycle W1C on the same bit.
        status_d = (status_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
        irq_d    = |status_q;
    end

    always_comb begin
        rd_word = '0;
        case (iADDRESS)
            6'd0: rd_word[PINS-1:0] = sync_out;
            6'd1: rd_word[PINS-1:0] = out_q;
            6'd2: rd_word[PINS-1:0] = dir_q;
            6'd3: rd_word[PINS-1:0] = rise_en_q;
            6'd4: rd_word[PINS-1:0] = fall_en_q;
            6'd5: rd_word[PINS-1:0] = status_q;
            default: begin
                for (int p = 0; p < PINS; p++) begin
                    if (iADDRESS == 6'(8 + p)) rd_word[MSW-1:0] = msel_q[p];
                end
            end
        endcase
        rdata_d = iREAD ? rd_word : rdata_q;
    end

    for (genvar p = 0; p < PINS; p++) begin : g_pin
        logic [FUNCS-1:0] f_oe, f_out;
        logic             msel_wr, sel_ok;

        assign f_oe[0]  = dir_q[p];
        assign f_out[0] = out_q[p];
        for (genvar f = 1; f < FUNCS; f++) begin : g_fn
            assign f_oe[f]  = iALT_OE[(f-1)*PINS + p];
            assign f_out[f] = iALT_OUT[(f-1)*PINS + p];
        end

        // Only a real change of selector opens a guard window; rewriting is a no-op.
        assign msel_wr    = iWRITE && (iADDRESS == 6'(8 + p)) &&
                            (iWRITE_DATA[MSW-1:0] != msel_q[p]);
        assign msel_d[p]  = msel_wr ? iWRITE_DATA[MSW-1:0] : msel_q[p];
        assign guard_d[p] = msel_wr ? 4'(GUARD) :
                            (guard_q[p] != 4'd0) ? guard_q[p] - 4'd1 : 4'd0;

        assign sel_ok       = (guard_q[p] == 4'd0) && (msel_q[p] < MSW'(FUNCS));
        assign pin_oe_d[p]  = sel_ok ? f_oe[msel_q[p][SELW-1:0]]  : 1'b0;
        assign pin_out_d[p] = sel_ok ? f_out[msel_q[p][SELW-1:0]] : 1'b0;
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            prev_q    <= '0;
            sync_q    <= '0;
            msel_q    <= '0;
            guard_q   <= '0;
            pin_out_q <= '0;
            pin_oe_q  <= '0;
            irq_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            prev_q    <= prev_d;
            sync_q    <= sync_d;
            msel_q    <= msel_d;
            guard_q   <= guard_d;
            pin_out_q <= pin_out_d;
            pin_oe_q  <= pin_oe_d;
            irq_q     <= irq_d;
            rdata_q   <= rdata_d;
        end
    end

    assign oREAD_DATA = rdata_q;
    assign oPIN_OUT   = pin_out_q;
    assign oPIN_OE    = pin_oe_q;
    assign oSYNC_IN   = sync_out;
    assign oIRQ       = irq_q;

endmodule
